// File: rtl/direction_key_filter_if.sv
// direction_key_filter_if: button inputs, game-enable and debounced key/heading outputs
interface direction_key_filter_if;
    logic       en;
    logic       btn_r, btn_l, btn_u, btn_d;
    logic       key_r, key_l, key_u, key_d;
    logic [1:0] dir;
    modport master(output en, btn_r, btn_l, btn_u, btn_d, input key_r, key_l, key_u, key_d, dir);
    modport slave(input en, btn_r, btn_l, btn_u, btn_d, output key_r, key_l, key_u, key_d, dir);
endinterface

// File: rtl/direction_key_filter.sv
// direction_key_filter: debounces four direction buttons into arbitrated single-cycle key pulses and a heading
module direction_key_filter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic clk,
    input logic rst,
    direction_key_filter_if.slave bus
);
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;
    localparam logic [19:0] LIMIT = 20'(DEBOUNCE_CYCLES - 1);
    logic [3:0] btn, evt, key_q;
    logic [1:0] dir_q, sel;
    logic       accept;
    assign btn = {bus.btn_d, bus.btn_u, bus.btn_l, bus.btn_r};
    for (genvar i = 0; i < 4; i++) begin : g_key
        key_state_t  st;
        logic [19:0] cnt;
        logic [1:0]  sync;
        logic        hit;
        // two-flop synchronizer for the asynchronous button
        always_ff @(posedge clk)
            sync <= rst ? 2'b00 : {sync[0], btn[i]};
        // debounce FSM; hit pulses on the edge a press qualifies, the counter is the count about to be reached minus one
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= RELEASED;
                cnt <= '0;
                hit <= 1'b0;
            end else begin
                hit <= 1'b0;
                case (st)
                    RELEASED:
                        if (sync[1]) begin
                            st  <= PRESS_WAIT;
                            cnt <= 20'd1;
                        end
                    PRESS_WAIT:
                        if (!sync[1]) begin
                            st  <= RELEASED;
                            cnt <= '0;
                        end else if (cnt == LIMIT) begin
                            st  <= HELD;
                            cnt <= '0;
                            hit <= 1'b1;
                        end else cnt <= cnt + 20'd1;
                    HELD:
                        if (!sync[1]) begin
                            st  <= RELEASE_WAIT;
                            cnt <= 20'd1;
                        end
                    default:
                        if (sync[1]) begin
                            st  <= HELD;
                            cnt <= '0;
                        end else if (cnt == LIMIT) begin
                            st  <= RELEASED;
                            cnt <= '0;
                        end else cnt <= cnt + 20'd1;
                endcase
            end
        end
        assign evt[i] = hit;
    end
    // priority R > L > U > D; the opposite of a heading differs only in its low bit
    always_comb begin
        sel    = evt[0] ? 2'd0 : evt[1] ? 2'd1 : evt[2] ? 2'd2 : 2'd3;
        accept = |evt && bus.en && ((sel ^ 2'b01) != dir_q);
    end
    // registered pulse and heading, reversal judged against the heading held before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
            dir_q <= 2'b00;
        end else begin
            key_q <= accept ? 4'b0001 << sel : 4'b0000;
            if (accept) dir_q <= sel;
        end
    end
    assign {bus.key_d, bus.key_u, bus.key_l, bus.key_r} = key_q;
    assign bus.dir = dir_q;
endmodule

// File: tb/tb_direction_key_filter.sv
// tb_direction_key_filter: directed scenarios plus random buttons checked against a run-length debounce model
module tb_direction_key_filter;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    direction_key_filter_if bus();
    direction_key_filter #(.DEBOUNCE_CYCLES(D)) dut(.clk(clk), .rst(rst), .bus(bus));
    int vectors = 0, miscompares = 0;
    logic [3:0] keys, btn;
    assign keys = {bus.key_d, bus.key_u, bus.key_l, bus.key_r};
    assign btn  = {bus.btn_d, bus.btn_u, bus.btn_l, bus.btn_r};

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // model: synced value is the button two edges back; the debounced level flips after D equal synced samples
    logic [3:0] h1 = '0, h2 = '0, deb = '0, last = '0, pend = '0, m_key = '0;
    logic [1:0] m_dir = '0;
    int run [4] = '{0, 0, 0, 0};
    always @(posedge clk) begin
        if (rst) begin
            h1 = '0; h2 = '0; deb = '0; last = '0; pend = '0; m_key = '0; m_dir = '0;
            for (int j = 0; j < 4; j++) run[j] = 0;
        end else begin
            m_key = '0;
            for (int j = 0; j < 4; j++)
                if (pend[j]) begin
                    if (bus.en && (j ^ 1) != int'(m_dir)) begin
                        m_key[j] = 1'b1;
                        m_dir = 2'(j);
                    end
                    break;
                end
            pend = '0;
            for (int j = 0; j < 4; j++) begin
                run[j] = (h2[j] == last[j]) ? run[j] + 1 : 1;
                last[j] = h2[j];
                if (h2[j] != deb[j] && run[j] >= D) begin
                    deb[j] = h2[j];
                    pend[j] = h2[j];
                end
            end
            h2 = h1;
            h1 = btn;
        end
    end

    int pc [4] = '{0, 0, 0, 0};
    always @(negedge clk) begin
        check("key", int'(keys), int'(m_key));
        check("dir", int'(bus.dir), int'(m_dir));
        check("onehot", int'($countones(keys) <= 1), 1);
        for (int j = 0; j < 4; j++) if (keys[j]) pc[j]++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] v);
        {bus.btn_d, bus.btn_u, bus.btn_l, bus.btn_r} = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.en = 1'b1; set_btn(4'b0000);
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_key(input int idx, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (keys[idx]) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, b0, b1, b2, b3;
        bus.en = 1'b1; set_btn(4'b0000);
        tick(3);
        check("reset_keys", int'(keys), 0);
        check("reset_dir", int'(bus.dir), 0);
        // clean press of up
        do_reset(); tick(2);
        b2 = pc[2];
        set_btn(4'b0100);
        wait_key(2, lat);
        check("up_latency", lat, D + 3);
        tick(12);
        check("up_dir", int'(bus.dir), 2);
        set_btn(4'b0000); tick(15);
        check("up_pulses", pc[2] - b2, 1);
        // bouncing right
        do_reset(); tick(2);
        b0 = pc[0];
        set_btn(4'b0001); tick(1); set_btn(4'b0000); tick(1);
        set_btn(4'b0001); tick(1); set_btn(4'b0000); tick(1);
        check("bounce_quiet", pc[0] - b0, 0);
        set_btn(4'b0001);
        wait_key(0, lat);
        check("bounce_latency", lat, D + 3);
        tick(10);
        check("bounce_pulses", pc[0] - b0, 1);
        set_btn(4'b0000); tick(12);
        // reversal lockout
        do_reset(); tick(2);
        b1 = pc[1]; b2 = pc[2]; b3 = pc[3];
        set_btn(4'b0010); tick(12); set_btn(4'b0000); tick(12);
        check("rev_l_pulses", pc[1] - b1, 0);
        check("rev_l_dir", int'(bus.dir), 0);
        set_btn(4'b1000); tick(12); set_btn(4'b0000); tick(12);
        check("rev_d_pulses", pc[3] - b3, 1);
        check("rev_d_dir", int'(bus.dir), 3);
        set_btn(4'b0100); tick(12); set_btn(4'b0000); tick(12);
        check("rev_u_pulses", pc[2] - b2, 0);
        check("rev_u_dir", int'(bus.dir), 3);
        // simultaneous up and down
        do_reset(); tick(2);
        b2 = pc[2]; b3 = pc[3];
        set_btn(4'b1100); tick(15);
        check("simul_u", pc[2] - b2, 1);
        check("simul_d", pc[3] - b3, 0);
        check("simul_dir", int'(bus.dir), 2);
        set_btn(4'b0000); tick(12);
        // enable gating
        do_reset(); tick(2);
        b3 = pc[3];
        bus.en = 1'b0; set_btn(4'b1000); tick(12);
        check("en0_pulses", pc[3] - b3, 0);
        check("en0_dir", int'(bus.dir), 0);
        bus.en = 1'b1; tick(10);
        check("en_rise_pulses", pc[3] - b3, 0);
        set_btn(4'b0000); tick(10);
        set_btn(4'b1000); tick(12);
        check("en1_pulses", pc[3] - b3, 1);
        check("en1_dir", int'(bus.dir), 3);
        set_btn(4'b0000); tick(12);
        // reset at count 3 of a held right press
        do_reset(); tick(2);
        b0 = pc[0];
        set_btn(4'b0001); tick(5);
        rst = 1'b1; tick(1); rst = 1'b0;
        wait_key(0, lat);
        check("rst_mid_latency", lat, D + 3);
        check("rst_mid_dir", int'(bus.dir), 0);
        tick(10);
        check("rst_mid_pulses", pc[0] - b0, 1);
        set_btn(4'b0000); tick(12);
        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 5) == 0) begin
                    logic [3:0] v;
                    v = btn;
                    v[j] = ~v[j];
                    set_btn(v);
                end
            if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0; tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/direction_key_filter.md
DIRECTION_KEY_FILTER -- requirements
Module: direction_key_filter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), number of consecutive stable synchronized samples that qualify a press or release; legal range 2..2^20.
REQ-002 clk  input  1  system clock; the single clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  game-running qualifier; 0 suppresses key pulses and direction updates.
REQ-005 btn_r, btn_l, btn_u, btn_d  input  1 each  raw board push-buttons, active-high, asynchronous, bouncing.
REQ-006 key_r, key_l, key_u, key_d  output  1 each  registered single-cycle press pulses feeding the snake motion controller's key_r/l/u/d inputs.
REQ-007 dir  output  2  current accepted heading, registered: 00 right, 01 left, 10 up, 11 down.

Function
REQ-008 Each btn_x SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-009 Each key SHALL have an independent 4-state FSM: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-010 RELEASED: sync input 1 -> PRESS_WAIT, counter cleared to 1; otherwise stay.
REQ-011 PRESS_WAIT: sync input 1 -> counter increments; on reaching DEBOUNCE_CYCLES -> HELD and raise a qualified-press event; sync input 0 at any count -> RELEASED, counter cleared.
REQ-012 HELD: sync input 0 -> RELEASE_WAIT, counter cleared to 1; otherwise stay (no repeat events while held).
REQ-013 RELEASE_WAIT: sync input 0 -> counter increments; on reaching DEBOUNCE_CYCLES -> RELEASED; sync input 1 at any count -> HELD, counter cleared, no new event.
REQ-014 Counters SHALL be 20 bits, saturate never (FSM exits at DEBOUNCE_CYCLES), and clear on every state change.
REQ-015 Latency: if clock edge k is the first edge sampling btn_x = 1 and btn_x stays 1, key_x SHALL be high exactly for the cycle following edge k+DEBOUNCE_CYCLES+2.
REQ-016 Arbitration: when several qualified-press events occur on the same edge, only the highest-priority key SHALL be considered, priority R > L > U > D; lower-priority events are dropped, not queued.
REQ-017 Reversal lockout: an event opposite to dir (R vs L, U vs D) SHALL produce no pulse and leave dir unchanged.
REQ-018 An accepted event (en = 1, not a reversal) SHALL assert exactly one key_x for one cycle and load dir with that direction on the same edge; same-direction events are accepted (pulse emitted, dir unchanged value).
REQ-019 At most one of key_r/l/u/d SHALL be high in any cycle.
REQ-020 With en = 0, FSMs and counters SHALL keep running; events are discarded, no pulse, dir held; a key already in HELD when en rises SHALL NOT generate a pulse.
REQ-021 Reversal check SHALL use the dir value before the current edge's update.

Reset
REQ-022 While rst = 1 at a clock edge: synchronizers cleared to 0, all FSMs to RELEASED, counters 0, key_r/l/u/d = 0, dir = 2'b00 (right).
REQ-023 Reset asserted mid-debounce SHALL abandon the count; after rst falls with a button still held, a full DEBOUNCE_CYCLES qualification SHALL be required before a pulse.
REQ-024 First edge with rst = 0 SHALL be a normal operating edge; no outputs change spuriously on reset release.

Verification (DEBOUNCE_CYCLES = 4, en = 1 unless stated)
REQ-025 Clean press: btn_u rises sampled at edge 10, held 20 cycles -> key_u high only in cycle after edge 16, dir = 10; release produces no pulse.
REQ-026 Bounce: btn_r toggles 1,0,1,0 every cycle then holds high -> exactly one key_r pulse, 6 edges after the final rising sample; none during bouncing.
REQ-027 Reversal: dir = 00 (reset), clean btn_l press -> no key_l pulse, dir stays 00; then btn_d press -> key_d pulse, dir = 11; then btn_u press -> no pulse.
REQ-028 Simultaneous: btn_u and btn_d rise on the same edge from dir = 00 -> only key_u pulses, dir = 10; key_d never asserted.
REQ-029 en gating: btn_d held and qualified with en = 0 -> no pulse, dir unchanged; en set to 1 while still held -> still no pulse; release and re-press -> one key_d pulse.
REQ-030 Reset mid-operation: assert rst for 1 cycle at count 3 of a btn_r press while held -> no pulse at the originally expected edge; pulse exactly DEBOUNCE_CYCLES+2 edges after the first post-reset edge, dir = 00.
